// File: rtl/ddr_burst_tx.sv
// FIFO-buffered burst writer: collects upstream words and emits them as fixed-length DDR write bursts.
// Optional macro DDR_TX_RANDOM_FILL_EN: start bursts without waiting for data, filling shortfalls from a 16-bit LFSR.
module ddr_burst_tx #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int BURST_LEN  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic              i_start,
    input  logic [7:0]        i_num_bursts,
    output logic              o_ddr_wen,
    output logic [DATA_W-1:0] o_ddr_data,
    output logic              o_busy,
    output logic              o_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        BURST     = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic              ready_r;
    state_t            state_r;
    logic [7:0]        remaining_r;
    logic [BW-1:0]     beat_r;
    logic [GW-1:0]     gap_r;
    logic              wen_r;
    logic [DATA_W-1:0] data_r;
    logic              done_r;
    logic              busy_r;
    logic              push_s;
    logic              pop_s;
    logic              go_s;
    logic              enough_s;
    logic              last_s;
    logic [DATA_W-1:0] word_s;

    assign push_s = i_valid & ready_r;
    assign last_s = (beat_r == BW'(BURST_LEN - 1));

`ifdef DDR_TX_RANDOM_FILL_EN
    logic [15:0] lfsr_r;
    logic        lfsr_adv_s;

    // Fibonacci taps 16,14,13,11 shifted in at the LSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    assign enough_s = 1'b1;

    // Burst word source: FIFO when it has data, LFSR otherwise
    always_comb begin
        word_s     = lfsr_r;
        pop_s      = 1'b0;
        lfsr_adv_s = 1'b0;
        if (count_r != CW'(0)) begin
            word_s = mem_r[rd_ptr_r];
            pop_s  = go_s;
        end else begin
            lfsr_adv_s = go_s;
        end
    end

    // Fill-pattern generator, advanced only when it supplies a word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= 16'hACE1;
        end else if (lfsr_adv_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    assign enough_s = (count_r >= CW'(BURST_LEN));
    assign word_s   = mem_r[rd_ptr_r];
    assign pop_s    = go_s;
`endif

    // A word goes out when a burst starts or continues
    always_comb begin
        go_s = 1'b0;
        case (state_r)
            WAIT_DATA: go_s = enough_s;
            BURST:     go_s = 1'b1;
            default:   go_s = 1'b0;
        endcase
    end

    // Next FIFO occupancy
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // FIFO pointers, occupancy and registered not-full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CW'(DEPTH));
        end
    end

    // Transfer sequencer with registered DDR outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            remaining_r <= 8'd0;
            beat_r      <= '0;
            gap_r       <= '0;
            wen_r       <= 1'b0;
            data_r      <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    wen_r <= 1'b0;
                    if (i_start) begin
                        remaining_r <= i_num_bursts;
                        busy_r      <= 1'b1;
                        beat_r      <= '0;
                        state_r     <= (i_num_bursts != 8'd0) ? WAIT_DATA : DONE;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                WAIT_DATA, BURST: begin
                    if (go_s) begin
                        wen_r  <= 1'b1;
                        data_r <= word_s;
                        if (last_s) begin
                            // Leaving on the last word keeps the idle time equal to GAP_CYCLES
                            beat_r      <= '0;
                            gap_r       <= '0;
                            remaining_r <= remaining_r - 8'd1;
                            if (remaining_r == 8'd1) begin
                                state_r <= DONE;
                            end else if (GAP_CYCLES == 0) begin
                                state_r <= WAIT_DATA;
                            end else begin
                                state_r <= GAP;
                            end
                        end else begin
                            beat_r  <= beat_r + BW'(1);
                            state_r <= BURST;
                        end
                    end else begin
                        wen_r <= 1'b0;
                    end
                end
                GAP: begin
                    wen_r <= 1'b0;
                    if (gap_r == GW'(GAP_CYCLES - 1)) begin
                        gap_r   <= '0;
                        state_r <= WAIT_DATA;
                    end else begin
                        gap_r <= gap_r + GW'(1);
                    end
                end
                DONE: begin
                    wen_r   <= 1'b0;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    wen_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_ready    = ready_r;
    assign o_ddr_wen  = wen_r;
    assign o_ddr_data = data_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
endmodule

// File: tb/tb_ddr_burst_tx.sv
// Directed self-checking bench for ddr_burst_tx (default parameters).
// Define DDR_TX_RANDOM_FILL_EN for both files to also exercise the LFSR fill mode.
module tb_ddr_burst_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = 16'd0;
    logic        o_ready;
    logic        i_start = 1'b0;
    logic [7:0]  i_num_bursts = 8'd0;
    logic        o_ddr_wen;
    logic [15:0] o_ddr_data;
    logic        o_busy;
    logic        o_done;

    int n_cmp = 0;
    int n_bad = 0;

    ddr_burst_tx dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .i_start      (i_start),
        .i_num_bursts (i_num_bursts),
        .o_ddr_wen    (o_ddr_wen),
        .o_ddr_data   (o_ddr_data),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Output log: emitted words, burst lengths, idle runs before each burst, done pulses
    logic [15:0] wq[$];
    int          runs[$];
    int          gaps[$];
    int          run_len = 0;
    int          idle_len = 0;
    int          done_cnt = 0;
    logic        prev_wen = 1'b0;

    always @(negedge clk) begin
        if (o_ddr_wen) begin
            wq.push_back(o_ddr_data);
            if (!prev_wen && wq.size() > 1) gaps.push_back(idle_len);
            run_len  = run_len + 1;
            idle_len = 0;
        end else begin
            if (prev_wen) runs.push_back(run_len);
            run_len  = 0;
            idle_len = idle_len + 1;
        end
        if (o_done) done_cnt = done_cnt + 1;
        prev_wen = o_ddr_wen;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v, output bit acc);
        i_valid = 1'b1;
        i_data  = v;
        acc     = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (o_ready) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic push_range(input int first, input int last, output bit all_ok);
        bit acc;
        all_ok = 1'b1;
        for (int v = first; v <= last; v++) begin
            push(16'(v), acc);
            if (!acc) all_ok = 1'b0;
        end
    endtask

    task automatic start(input logic [7:0] n);
        i_start      = 1'b1;
        i_num_bursts = n;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_words(input string tag, input int base, input int first, input int cnt);
        check({tag, "_count"}, 32'(wq.size() - base), 32'(cnt));
        for (int k = 0; k < cnt; k++) begin
            if (base + k < wq.size()) check(tag, 32'(wq[base + k]), 32'(first + k));
        end
    endtask

    initial begin
        bit ok;
        int base, rb, gb, db;

        // Reset values while held in reset
        #12;
        check("rst_wen", 32'(o_ddr_wen), 32'd0);
        check("rst_data", 32'(o_ddr_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        tick();
        rst = 1'b1;
        check("ready_before_edge", 32'(o_ready), 32'd0);
        tick();
        check("ready_after_edge", 32'(o_ready), 32'd1);

        // Single burst of 1..8 with latency and done/busy timing
        push_range(1, 8, ok);
        check("pre8_accept", 32'(ok), 32'd1);
        base = wq.size(); rb = runs.size(); db = done_cnt;
        start(8'd1);
        check("b1_wen_e0", 32'(o_ddr_wen), 32'd0);
        check("b1_busy_e0", 32'(o_busy), 32'd1);
        tick();
        check("b1_wen_e1", 32'(o_ddr_wen), 32'd1);
        check("b1_data_e1", 32'(o_ddr_data), 32'd1);
        wait_idle(ok);
        check("b1_idle_timeout", 32'(ok), 32'd1);
        check("b1_done_pulse", 32'(o_done), 32'd1);
        tick();
        check("b1_done_drop", 32'(o_done), 32'd0);
        check("b1_data_hold", 32'(o_ddr_data), 32'd8);
        check("b1_wen_low", 32'(o_ddr_wen), 32'd0);
        check_words("b1_word", base, 1, 8);
        check("b1_runlen", 32'(runs[runs.size() - 1]), 32'd8);
        check("b1_ndone", 32'(done_cnt - db), 32'd1);

        // Zero bursts: straight to DONE
        base = wq.size();
        start(8'd0);
        check("z_busy_e0", 32'(o_busy), 32'd1);
        check("z_done_e0", 32'(o_done), 32'd0);
        tick();
        check("z_done_e1", 32'(o_done), 32'd1);
        check("z_busy_e1", 32'(o_busy), 32'd0);
        tick();
        check("z_done_e2", 32'(o_done), 32'd0);
        check("z_no_wen", 32'(wq.size() - base), 32'd0);

        // Fill to full, overflow word dropped
        push_range(1, 16, ok);
        check("full_accept", 32'(ok), 32'd1);
        check("full_ready", 32'(o_ready), 32'd0);
        i_valid = 1'b1;
        i_data  = 16'd17;
        tick();
        tick();
        i_valid = 1'b0;
        check("full_ready_hold", 32'(o_ready), 32'd0);
        base = wq.size();
        start(8'd1);
        wait_idle(ok);
        check("full_idle_timeout", 32'(ok), 32'd1);
        tick();
        check_words("full_word", base, 1, 8);
        check("full_ready_after", 32'(o_ready), 32'd1);

        // Reset on the 4th word of a burst (FIFO holds 9..16)
        base = wq.size(); db = done_cnt;
        start(8'd1);
        tick(); tick(); tick(); tick();
        check("mid_wen_4th", 32'(o_ddr_wen), 32'd1);
        check("mid_data_4th", 32'(o_ddr_data), 32'd12);
        rst = 1'b0;
        #1;
        check("mid_rst_wen", 32'(o_ddr_wen), 32'd0);
        check("mid_rst_data", 32'(o_ddr_data), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_ready", 32'(o_ready), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("mid_ready_back", 32'(o_ready), 32'd1);
        check("mid_no_done", 32'(done_cnt - db), 32'd0);
        check("mid_words_seen", 32'(wq.size() - base), 32'd3);
        push_range(101, 108, ok);
        check("post_accept", 32'(ok), 32'd1);
        base = wq.size(); db = done_cnt;
        start(8'd1);
        wait_idle(ok);
        check("post_idle_timeout", 32'(ok), 32'd1);
        tick();
        check_words("post_word", base, 101, 8);
        check("post_ndone", 32'(done_cnt - db), 32'd1);

        // Three bursts with continuous feed and 2-cycle gaps
        push_range(1, 16, ok);
        check("m_pre_accept", 32'(ok), 32'd1);
        base = wq.size(); rb = runs.size(); gb = gaps.size(); db = done_cnt;
        start(8'd3);
        push_range(17, 24, ok);
        check("m_feed_accept", 32'(ok), 32'd1);
        wait_idle(ok);
        check("m_idle_timeout", 32'(ok), 32'd1);
        tick();
        check_words("m_word", base, 1, 24);
        check("m_nruns", 32'(runs.size() - rb), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (rb + k < runs.size()) check("m_runlen", 32'(runs[rb + k]), 32'd8);
        end
        check("m_ngaps", 32'(gaps.size() - gb), 32'd3);
        for (int k = 1; k < 3; k++) begin
            if (gb + k < gaps.size()) check("m_gap", 32'(gaps[gb + k]), 32'd2);
        end
        check("m_ndone", 32'(done_cnt - db), 32'd1);

`ifdef DDR_TX_RANDOM_FILL_EN
        // Empty FIFO: burst is all LFSR words from the reset seed
        base = wq.size(); rb = runs.size();
        start(8'd1);
        wait_idle(ok);
        check("lfsr_idle_timeout", 32'(ok), 32'd1);
        tick();
        check("lfsr_count", 32'(wq.size() - base), 32'd8);
        if (base + 1 < wq.size()) begin
            check("lfsr_w0", 32'(wq[base]), 32'h0000ACE1);
            check("lfsr_w1", 32'(wq[base + 1]), 32'h000059C3);
        end
        check("lfsr_runlen", 32'(runs[runs.size() - 1]), 32'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
